// File: rtl/not_share_arb_pkg.sv
// Shared constants and types for the not_share_arb arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Holds the FSM state encoding, the transfer-counter width and the
// saturating increment used by the counter.
package not_share_arb_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/not_share_arb_not_vec.sv
// Shared bitwise inverter datapath: y = ~a.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no state and no handshake.
//
// Ports: a (W) operand in, y (W) inverted result out.
module not_vec #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = ~a;

endmodule

// File: rtl/not_share_arb.sv
// Round-robin arbiter that shares one not_vec inverter among N_REQ requesters.
// Latency: req sampled at t, gnt in t+1, out_valid in t+2, IDLE again at t+3.
// Backpressure: holds the result in RESP while out_ready is low; no new grant until accepted.
//
// Ports: clk/rst_n (async active-low); req/req_data from requesters;
// gnt one-hot capture pulse; busy while not IDLE; out_valid/out_ready/
// out_data/out_id result port; op_cnt saturating count of completed transfers.
module not_share_arb
    import not_share_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic [IDW-1:0]     out_id,
    output logic [CNT_W-1:0]   op_cnt
);

    state_t             state_q;
    state_t             state_d;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     id_q;
    logic [IDW-1:0]     win;
    logic [W-1:0]       opnd_q;
    logic [W-1:0]       res_q;
    logic [W-1:0]       inv_y;
    logic [W-1:0]       win_data;
    logic [N_REQ-1:0]   gnt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               take;
    logic               accept;

    // Wrap N_REQ-1 back to 0 explicitly so non-power-of-two N_REQ works.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        if (int'(i) == N_REQ - 1) begin
            return '0;
        end
        return i + IDW'(1);
    endfunction

    // First requester at or after p, searching upward with wrap-around.
    function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDW-1:0]   p);
        logic [IDW-1:0] w;
        logic [IDW-1:0] idx;
        logic           found;
        w     = p;
        idx   = p;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        return w;
    endfunction

    assign win      = rr_pick(req, ptr_q);
    assign win_data = req_data[win*W +: W];

    not_vec #(.W(W)) u_inv (
        .a (opnd_q),
        .y (inv_y)
    );

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    take    = 1'b1;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (out_ready) begin
                    accept  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // Grant is a registered one-cycle pulse coinciding with EVAL.
            gnt_q   <= take ? (N_REQ'(1) << win) : '0;
            if (take) begin
                opnd_q <= win_data;
                id_q   <= win;
            end
            if (state_q == ST_EVAL) begin
                res_q <= inv_y;
            end
            // The served requester drops to lowest priority next time.
            if (accept) begin
                ptr_q <= next_idx(id_q);
                cnt_q <= sat_inc(cnt_q);
            end
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_RESP);
    assign out_data  = res_q;
    assign out_id    = id_q;
    assign op_cnt    = cnt_q;

endmodule

// File: tb/tb_not_share_arb.sv
module tb_not_share_arb;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    gnt;
    logic            busy;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [IDW-1:0]  out_id;
    logic [15:0]     op_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state: next-priority index and completed-transfer count.
    int          m_ptr = 0;
    int unsigned m_cnt = 0;

    not_share_arb #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .op_cnt    (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Circular search from the model pointer: first requesting index wins.
    function automatic int model_pick(input logic [N-1:0] m, input int p);
        for (int i = 0; i < N; i++) begin
            if (m[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_cnt = 0;
    endtask

    // One full transfer. Entered and left at a negedge with the DUT in IDLE.
    // mask: req during arbitration; hold: req while busy; delay: stall cycles.
    task automatic txn(input logic [N-1:0] mask, input logic [N*W-1:0] dat,
                       input int delay, input logic [N-1:0] hold, output int got);
        int             w;
        logic [N-1:0]   eg;
        logic [W-1:0]   ed;
        w  = model_pick(mask, m_ptr);
        eg = 4'b0001 << w;
        ed = ~dat[w*W +: W];
        req       = mask;
        req_data  = dat;
        out_ready = (delay == 0);
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("busy_eval", 32'(busy), 32'd1);
        chk("valid_eval", 32'(out_valid), 32'd0);
        got = -1;
        for (int i = 0; i < N; i++) if (gnt[i]) got = i;
        req = hold;
        @(negedge clk);
        chk("valid_resp", 32'(out_valid), 32'd1);
        chk("data_resp", 32'(out_data), 32'(ed));
        chk("id_resp", 32'(out_id), 32'(w));
        chk("gnt_pulse", 32'(gnt), 32'd0);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("valid_hold", 32'(out_valid), 32'd1);
            chk("data_hold", 32'(out_data), 32'(ed));
            chk("id_hold", 32'(out_id), 32'(w));
            chk("gnt_hold", 32'(gnt), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        m_ptr = (w + 1) % N;
        if (m_cnt != 32'hFFFF) m_cnt = m_cnt + 1;
        chk("valid_done", 32'(out_valid), 32'd0);
        chk("busy_done", 32'(busy), 32'd0);
        chk("op_cnt", 32'(op_cnt), m_cnt);
    endtask

    initial begin
        int got;
        int order [5];
        logic [N*W-1:0] dat;
        order = '{0, 1, 2, 3, 0};

        rst_n     = 1'b0;
        req       = '0;
        req_data  = '0;
        out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_cnt", 32'(op_cnt), 32'd0);
        end

        // Single request from requester 2
        dat = 32'h003C_0000;
        txn(4'b0100, dat, 0, 4'b0000, got);
        chk("single_id", 32'(got), 32'd2);
        chk("single_cnt", 32'(op_cnt), 32'd1);

        // Short reset so fairness starts from index 0
        req   = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);

        // Fairness with everyone requesting
        for (int k = 0; k < 5; k++) begin
            dat = $urandom;
            txn(4'b1111, dat, 0, 4'b1111, got);
            chk("fair_order", 32'(got), 32'(order[k]));
        end
        chk("fair_cnt", 32'(op_cnt), 32'd5);

        // Backpressure on requester 1 with operand A5
        dat = 32'h0000_A500;
        txn(4'b0010, dat, 5, 4'b0011, got);
        chk("bp_id", 32'(got), 32'd1);
        dat = $urandom;
        txn(4'b0011, dat, 0, 4'b0000, got);
        chk("bp_next", 32'(got), 32'd0);

        // Reset while in EVAL
        req      = 4'b1000;
        req_data = 32'h7700_0000;
        @(negedge clk);
        chk("mid_gnt", 32'(gnt), 32'h8);
        rst_n = 1'b0;
        #1;
        chk("mid_gnt0", 32'(gnt), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_data", 32'(out_data), 32'd0);
        chk("mid_id", 32'(out_id), 32'd0);
        chk("mid_cnt", 32'(op_cnt), 32'd0);
        model_reset();
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(out_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            logic [N-1:0] m;
            logic [N-1:0] h;
            m   = N'($urandom_range(1, 15));
            h   = N'($urandom_range(0, 15));
            dat = $urandom;
            txn(m, dat, $urandom_range(0, 3), h, got);
            if ($urandom_range(0, 3) == 0) begin
                req = '0;
                @(negedge clk);
                chk("gap_gnt", 32'(gnt), 32'd0);
                chk("gap_busy", 32'(busy), 32'd0);
            end
        end

        // Saturation: preload the counter at its ceiling
        req = '0;
        force dut.cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.cnt_q;
        @(negedge clk);
        m_cnt = 32'hFFFF;
        chk("sat_pre", 32'(op_cnt), 32'hFFFF);
        dat = $urandom;
        txn(4'b0001, dat, 1, 4'b0000, got);
        chk("sat_post", 32'(op_cnt), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
